ttt_auto_player: RTL

- Automated opponent that drives the game block's nine cell buttons (a..i).
- The game consumes button presses; this block produces them, acting as player 1 or player 2 from board ownership and turn/status flags.
- Runs a sequential move search with priority order win > block > preference list.
- Emits a single-cell press pulse, then waits for the game to acknowledge by moving the turn.

---
 rtl/ttt_pkg.sv | 20 ++
 rtl/ttt_auto_player_if.sv | 7 +
 rtl/ttt_line_eval.sv | 21 ++
 rtl/ttt_auto_player.sv | 110 +++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// ttt_pkg: cell indices, line and preference tables, FSM states and turn decode for the autoplayer
package ttt_pkg;
    localparam logic [3:0] CELL_A = 4'd0, CELL_B = 4'd1, CELL_C = 4'd2;
    localparam logic [3:0] CELL_D = 4'd3, CELL_E = 4'd4, CELL_F = 4'd5;
    localparam logic [3:0] CELL_G = 4'd6, CELL_H = 4'd7, CELL_I = 4'd8;
    localparam logic [3:0] NO_MOVE = 4'hF;
    localparam logic [3:0] LINE [8][3] = '{
        '{CELL_A, CELL_B, CELL_C}, '{CELL_D, CELL_E, CELL_F}, '{CELL_G, CELL_H, CELL_I},
        '{CELL_A, CELL_D, CELL_G}, '{CELL_B, CELL_E, CELL_H}, '{CELL_C, CELL_F, CELL_I},
        '{CELL_A, CELL_E, CELL_I}, '{CELL_C, CELL_E, CELL_G}
    };
    localparam logic [3:0] PREF_ORDER [9] = '{
        CELL_E, CELL_A, CELL_C, CELL_G, CELL_I, CELL_B, CELL_D, CELL_F, CELL_H
    };
    typedef enum logic [2:0] {IDLE, SNAP, WIN, BLOCK, PREF, PRESS, GAP, ACK} state_t;
    // Contradictory turn flags (both or neither) never count as our turn.
    function automatic logic turn_of(input logic pa, input logic p1t, input logic p2t);
        return pa ? (p2t & ~p1t) : (p1t & ~p2t);
    endfunction
endpackage

// File: rtl/ttt_auto_player_if.sv
// ttt_auto_player_if: board state and button bus between game (slave) and autoplayer (master)
interface ttt_auto_player_if;
    logic [8:0] p1_cells, p2_cells, btn;
    logic p1_turn, p2_turn, p1_win, p2_win, grid_full;
    modport master (output btn, input p1_cells, p2_cells, p1_turn, p2_turn, p1_win, p2_win, grid_full);
    modport slave (input btn, output p1_cells, p2_cells, p1_turn, p2_turn, p1_win, p2_win, grid_full);
endinterface

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: flags a line holding two marks and one empty cell, returning the empty cell
module ttt_line_eval
    import ttt_pkg::*;
(
    input  logic [8:0] mark,
    input  logic [8:0] empty,
    input  logic [2:0] line,
    output logic       hit,
    output logic [3:0] target
);
    logic [3:0] c0, c1, c2;
    assign c0 = LINE[line][0];
    assign c1 = LINE[line][1];
    assign c2 = LINE[line][2];
    always_comb begin
        target = (empty[c0] && mark[c1] && mark[c2]) ? c0 :
                 (empty[c1] && mark[c0] && mark[c2]) ? c1 :
                 (empty[c2] && mark[c0] && mark[c1]) ? c2 : NO_MOVE;
    end
    assign hit = target != NO_MOVE;
endmodule

// File: rtl/ttt_auto_player.sv
// ttt_auto_player: searches win > block > preference on a board snapshot, then pulses one button
module ttt_auto_player
    import ttt_pkg::*;
#(
    parameter int PRESS_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    play_as,
    ttt_auto_player_if.master       game,
    output logic                    busy,
    output logic [3:0]              last_move,
    output logic                    err
);
    state_t     state;
    logic [7:0] cnt;
    logic       pa_q, early, my_turn, over, line_hit, sel_hit;
    logic [8:0] mine, theirs, empty;
    logic [3:0] line_tgt, pref_cell, sel_cell;
    assign my_turn   = turn_of(state == IDLE ? play_as : pa_q, game.p1_turn, game.p2_turn);
    assign over      = game.p1_win | game.p2_win | game.grid_full;
    assign busy      = state != IDLE;
    assign pref_cell = PREF_ORDER[cnt[3:0]];
    assign sel_hit   = state == PREF ? empty[pref_cell] : line_hit;
    assign sel_cell  = state == PREF ? pref_cell : line_tgt;
    ttt_line_eval u_line_eval (
        .mark   (state == BLOCK ? theirs : mine),
        .empty  (empty),
        .line   (cnt[2:0]),
        .hit    (line_hit),
        .target (line_tgt)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pa_q      <= 1'b0;
            early     <= 1'b0;
            mine      <= '0;
            theirs    <= '0;
            empty     <= '0;
            game.btn  <= '0;
            last_move <= NO_MOVE;
            err       <= 1'b0;
        end else if (state != IDLE && (!enable || over)) begin
            state    <= IDLE;
            cnt      <= '0;
            game.btn <= '0;
        end else begin
            case (state)
                IDLE: if (enable && my_turn && !over) begin
                    state <= SNAP;
                    pa_q  <= play_as;
                end
                SNAP: if (!my_turn) state <= IDLE;
                else begin
                    mine   <= pa_q ? game.p2_cells : game.p1_cells;
                    theirs <= pa_q ? game.p1_cells : game.p2_cells;
                    empty  <= ~(game.p1_cells | game.p2_cells);
                    cnt    <= '0;
                    state  <= WIN;
                end
                WIN, BLOCK, PREF: if (!my_turn) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (sel_hit) begin
                    state     <= PRESS;
                    game.btn  <= 9'b1 << sel_cell;
                    last_move <= sel_cell;
                    early     <= 1'b0;
                    cnt       <= '0;
                end else if (state == PREF && cnt == 8'd8) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (state != PREF && cnt == 8'd7) begin
                    state <= state == WIN ? BLOCK : PREF;
                    cnt   <= '0;
                end else cnt <= cnt + 8'd1;
                PRESS: begin
                    early <= early | ~my_turn;
                    if (cnt == 8'(PRESS_CYCLES - 1)) begin
                        state    <= GAP;
                        game.btn <= '0;
                        cnt      <= '0;
                    end else cnt <= cnt + 8'd1;
                end
                // A handover seen while pressing counts as the ack once the gap completes.
                GAP: begin
                    early <= early | ~my_turn;
                    if (cnt == 8'(GAP_CYCLES - 1)) begin
                        state <= (early || !my_turn) ? IDLE : ACK;
                        cnt   <= '0;
                    end else cnt <= cnt + 8'd1;
                end
                ACK: if (!my_turn) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
                    err   <= 1'b1;
                    state <= IDLE;
                    cnt   <= '0;
                end else cnt <= cnt + 8'd1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
